axi_slave_rd: RTL and testbench

AXI4 read-channel slave (responder) that accepts AR requests and returns R bursts from a synchronous on-chip memory port with 1-cycle read latency.
It is the far end of the team's AXI4 read master. It serves as the simulation/BRAM target for the DDR3 controller path and as a stand-in for the MIG in unit benches.
A 2-entry output FIFO absorbs memory latency, so rready backpressure never loses data.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_rd_fifo2.sv | 51 +++++
 rtl/axi_slave_rd.sv | 153 +++++++++++++++
 tb/tb_axi_slave_rd.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 read-path constants, state encoding and FIFO beat layout.
package axi_pkg;

   localparam int unsigned AXI_ADDR_W = 30;
   localparam int unsigned AXI_DATA_W = 64;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   // Two bits so that the unused encodings exist and recover to IDLE
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BURST = 2'b01
   } rd_state_e;

   // One R beat as stored in the output FIFO
   typedef struct packed {
      logic                  last;
      logic [1:0]            resp;
      logic [AXI_DATA_W-1:0] data;
   } rd_beat_t;

endpackage

// File: rtl/axi_rd_fifo2.sv
// Two-entry registered FIFO holding R beats {rlast, rresp, rdata}.
module axi_rd_fifo2
   import axi_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  rd_beat_t   i_data,
   input  logic       i_pop,
   output rd_beat_t   o_head,
   output logic [1:0] o_count,
   output logic       o_empty,
   output logic       o_full
);

   rd_beat_t   r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_do_push;
   logic       w_do_pop;

   assign o_count   = r_count;
   assign o_empty   = (r_count == 2'd0);
   assign o_full    = (r_count == 2'd2);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage, pointers and occupancy
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
      end
   end

endmodule

// File: rtl/axi_slave_rd.sv
// AXI4 read-channel slave serving R bursts from a 1-cycle-latency memory port.
module axi_slave_rd
   import axi_pkg::*;
#(
   parameter int unsigned MEM_ADDR_W = 12,
   parameter int unsigned ID_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       s_axi_arid,
   input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [ID_W-1:0]       s_axi_rid,
   output logic [AXI_DATA_W-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  mem_rd_en,
   output logic [MEM_ADDR_W-1:0] mem_rd_addr,
   input  logic [AXI_DATA_W-1:0] mem_rd_data,
   output logic                  busy
);

   localparam int unsigned WADDR_W = AXI_ADDR_W - 3;

   rd_state_e          r_state;
   rd_state_e          w_next_state;
   logic               r_arready;
   logic [ID_W-1:0]    r_id;
   logic [WADDR_W-1:0] r_addr;
   logic [7:0]         r_len;
   logic               r_fixed;
   logic [8:0]         r_issued;
   logic               r_inflight;
   logic               r_inflight_oor;
   logic               r_inflight_last;

   logic               w_ar_hs;
   logic               w_pop;
   logic               w_issue;
   logic               w_oor;
   logic               w_last_slot;
   logic               w_final_hs;
   logic [2:0]         w_occupancy;
   logic [1:0]         w_fifo_count;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   rd_beat_t           w_head;
   rd_beat_t           w_push_beat;
   logic               w_unused;

   assign w_unused = ^{s_axi_arsize, s_axi_araddr[2:0], w_fifo_full};

   assign w_ar_hs     = (r_state == IDLE) & s_axi_arvalid & r_arready;
   assign w_pop       = s_axi_rvalid & s_axi_rready;
   assign w_final_hs  = w_pop & w_head.last;
   // Beats already committed to the FIFO after this cycle's pop
   assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_oor       = (r_addr >> MEM_ADDR_W) != '0;
   assign w_last_slot = (r_issued == {1'b0, r_len});
   assign w_issue     = (r_state == BURST) & (r_issued < ({1'b0, r_len} + 9'd1))
                        & (w_occupancy < 3'd2);

   // Out-of-range slots still flow through the pipeline but never touch memory
   assign mem_rd_en   = w_issue & ~w_oor;
   assign mem_rd_addr = r_addr[MEM_ADDR_W-1:0];

   assign w_push_beat.last = r_inflight_last;
   assign w_push_beat.resp = r_inflight_oor ? RESP_SLVERR : RESP_OKAY;
   assign w_push_beat.data = r_inflight_oor ? '0 : mem_rd_data;

   assign s_axi_arready = r_arready;
   assign s_axi_rid     = r_id;
   assign s_axi_rvalid  = ~w_fifo_empty;
   assign s_axi_rdata   = w_head.data;
   assign s_axi_rresp   = w_head.resp;
   assign s_axi_rlast   = w_head.last;
   assign busy          = (r_state != IDLE);

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_ar_hs) w_next_state = BURST;
         BURST:   if (w_final_hs) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register and registered arready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_arready <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_arready <= (w_next_state == IDLE);
      end
   end

   // Burst context: latched on AR, advanced on every issued slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id     <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_fixed  <= 1'b0;
         r_issued <= '0;
      end else if (w_ar_hs) begin
         r_id     <= s_axi_arid;
         r_addr   <= s_axi_araddr[AXI_ADDR_W-1:3];
         r_len    <= s_axi_arlen;
         r_fixed  <= (s_axi_arburst == BURST_FIXED);
         r_issued <= '0;
      end else if (w_issue) begin
         r_issued <= r_issued + 9'd1;
         if (!r_fixed) begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   // Tags for the slot whose memory data arrives next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight      <= 1'b0;
         r_inflight_oor  <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_oor  <= w_oor;
         r_inflight_last <= w_last_slot;
      end
   end

   axi_rd_fifo2 u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (r_inflight),
      .i_data  (w_push_beat),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

endmodule

// File: tb/tb_axi_slave_rd.sv
// Directed bench for axi_slave_rd with a 16-word backing memory.
module tb_axi_slave_rd;

   localparam int unsigned MEM_ADDR_W = 4;
   localparam int unsigned ID_W       = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [ID_W-1:0]       s_axi_arid = '0;
   logic [29:0]           s_axi_araddr = '0;
   logic [7:0]            s_axi_arlen = '0;
   logic [2:0]            s_axi_arsize = 3'd3;
   logic [1:0]            s_axi_arburst = 2'b01;
   logic                  s_axi_arvalid = 1'b0;
   logic                  s_axi_arready;
   logic [ID_W-1:0]       s_axi_rid;
   logic [63:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rlast;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready = 1'b0;
   logic                  mem_rd_en;
   logic [MEM_ADDR_W-1:0] mem_rd_addr;
   logic [63:0]           mem_rd_data;
   logic                  busy;

   logic [63:0] mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0]           q_data [$];
   logic [1:0]            q_resp [$];
   logic                  q_last [$];
   logic [ID_W-1:0]       q_rid  [$];
   int                    q_cyc  [$];
   logic [MEM_ADDR_W-1:0] q_addr [$];
   int                    issue_viol;
   int                    stab_viol;
   logic                  arready_after;
   logic                  done_flag;

   always #5 clk = ~clk;

   // Synchronous memory, data valid the cycle after the strobe
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
   end

   axi_slave_rd #(
      .MEM_ADDR_W (MEM_ADDR_W),
      .ID_W       (ID_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_arid    (s_axi_arid),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_arsize  (s_axi_arsize),
      .s_axi_arburst (s_axi_arburst),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rid     (s_axi_rid),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rlast   (s_axi_rlast),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 16; i++) mem[i] = 64'(100 + i);
   endtask

   // Issue one AR at a negedge and collect beats until rlast or timeout.
   // pat[c] is rready for cycle c counted from the AR cycle (1 beyond bit 31).
   task automatic do_burst(input logic [ID_W-1:0] id, input logic [29:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [31:0] pat);
      int         c;
      int         outstanding;
      logic       hold_v;
      logic [66:0] hold_b;
      logic       pop;
      q_data.delete(); q_resp.delete(); q_last.delete();
      q_rid.delete();  q_cyc.delete();  q_addr.delete();
      issue_viol = 0; stab_viol = 0; done_flag = 1'b0; arready_after = 1'b1;
      for (int w = 0; w < 20 && !s_axi_arready; w++) @(negedge clk);
      check("arready_before_ar", 64'(s_axi_arready), 64'd1);
      s_axi_arid    = id;
      s_axi_araddr  = addr;
      s_axi_arlen   = len;
      s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = pat[0];
      c = 0; outstanding = 0; hold_v = 1'b0; hold_b = '0;
      while (!done_flag && c < 80) begin
         #1;
         pop = s_axi_rvalid & s_axi_rready;
         if (c == 1) arready_after = s_axi_arready;
         if (mem_rd_en) begin
            q_addr.push_back(mem_rd_addr);
            if (outstanding - int'(pop) >= 2) issue_viol++;
         end
         if (hold_v && (!s_axi_rvalid || {s_axi_rlast, s_axi_rresp, s_axi_rdata} != hold_b))
            stab_viol++;
         hold_v = s_axi_rvalid & ~s_axi_rready;
         hold_b = {s_axi_rlast, s_axi_rresp, s_axi_rdata};
         if (pop) begin
            q_data.push_back(s_axi_rdata);
            q_resp.push_back(s_axi_rresp);
            q_last.push_back(s_axi_rlast);
            q_rid.push_back(s_axi_rid);
            q_cyc.push_back(c);
            if (s_axi_rlast) done_flag = 1'b1;
         end
         outstanding = outstanding + int'(mem_rd_en) - int'(pop);
         @(negedge clk);
         c++;
         s_axi_arvalid = 1'b0;
         s_axi_rready  = (c < 32) ? pat[c] : 1'b1;
      end
      check("burst_done", 64'(done_flag), 64'd1);
      check("arready_after_hs", 64'(arready_after), 64'd0);
   endtask

   initial begin
      logic [31:0] pat;
      int          pops;
      int          rv_seen;

      fill_mem();
      // Reset values
      @(negedge clk);
      #1;
      check("rst_ctrl", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid,
                              busy, mem_rd_en, mem_rd_addr}), 64'd0);
      check("rst_rdata", s_axi_rdata, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("arready_post_rst", 64'(s_axi_arready), 64'd1);

      // Single beat: word 2, latency 3 cycles
      mem[2] = 64'hA5A5;
      do_burst(4'h5, 30'h10, 8'd0, 2'b01, 32'hFFFF_FFFF);
      check("t1_nbeats", 64'(q_data.size()), 64'd1);
      if (q_data.size() > 0) begin
         check("t1_data", q_data[0], 64'hA5A5);
         check("t1_last", 64'(q_last[0]), 64'd1);
         check("t1_resp", 64'(q_resp[0]), 64'd0);
         check("t1_rid", 64'(q_rid[0]), 64'h5);
         check("t1_latency", 64'(q_cyc[0]), 64'd3);
      end
      check("t1_idle_busy", 64'(busy), 64'd0);
      check("t1_idle_arready", 64'(s_axi_arready), 64'd1);

      // INCR burst, full throughput
      fill_mem();
      do_burst(4'h3, 30'h0, 8'd3, 2'b01, 32'hFFFF_FFFF);
      check("t2_nbeats", 64'(q_data.size()), 64'd4);
      for (int i = 0; i < q_data.size(); i++) begin
         check("t2_data", q_data[i], 64'(100 + i));
         check("t2_last", 64'(q_last[i]), 64'(i == 3));
         check("t2_cycle", 64'(q_cyc[i]), 64'(3 + i));
      end
      check("t2_naddr", 64'(q_addr.size()), 64'd4);
      for (int i = 0; i < q_addr.size(); i++) check("t2_addr", 64'(q_addr[i]), 64'(i));

      // Backpressure: words 4..11
      pat = 32'hFFFF_FFFF;
      pat[4] = 1'b0; pat[5] = 1'b0; pat[12:8] = 5'b0; pat[14] = 1'b0;
      do_burst(4'h9, 30'h20, 8'd7, 2'b01, pat);
      check("t3_nbeats", 64'(q_data.size()), 64'd8);
      for (int i = 0; i < q_data.size(); i++) begin
         check("t3_data", q_data[i], 64'(104 + i));
         check("t3_last", 64'(q_last[i]), 64'(i == 7));
      end
      check("t3_nissue", 64'(q_addr.size()), 64'd8);
      check("t3_issue_rule", 64'(issue_viol), 64'd0);
      check("t3_stall_stable", 64'(stab_viol), 64'd0);

      // FIXED burst on word 8
      mem[8] = 64'hF1F1_0008;
      do_burst(4'h2, 30'h40, 8'd2, 2'b00, 32'hFFFF_FFFF);
      check("t4_nbeats", 64'(q_data.size()), 64'd3);
      for (int i = 0; i < q_data.size(); i++) check("t4_data", q_data[i], 64'hF1F1_0008);
      check("t4_naddr", 64'(q_addr.size()), 64'd3);
      for (int i = 0; i < q_addr.size(); i++) check("t4_addr", 64'(q_addr[i]), 64'd8);

      // Out of range: words 14,15 valid, 16,17 SLVERR
      mem[14] = 64'hE14; mem[15] = 64'hE15;
      do_burst(4'h7, 30'h70, 8'd3, 2'b01, 32'hFFFF_FFFF);
      check("t5_nbeats", 64'(q_data.size()), 64'd4);
      if (q_data.size() == 4) begin
         check("t5_d0", q_data[0], 64'hE14);
         check("t5_d1", q_data[1], 64'hE15);
         check("t5_d2", q_data[2], 64'd0);
         check("t5_d3", q_data[3], 64'd0);
         check("t5_resp", 64'({q_resp[0], q_resp[1], q_resp[2], q_resp[3]}), 64'b00_00_10_10);
         check("t5_last", 64'({q_last[0], q_last[1], q_last[2], q_last[3]}), 64'b0001);
      end
      check("t5_nissue", 64'(q_addr.size()), 64'd2);

      // Reset while beat 2 is presented
      fill_mem();
      for (int w = 0; w < 20 && !s_axi_arready; w++) @(negedge clk);
      s_axi_arid = 4'hC; s_axi_araddr = 30'h0; s_axi_arlen = 8'd7;
      s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      pops = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         s_axi_arvalid = 1'b0;
         #1;
         if (s_axi_rvalid && pops == 2) break;
         if (s_axi_rvalid && s_axi_rready) pops++;
      end
      check("t6_reached_beat2", 64'(pops), 64'd2);
      rst = 1'b1;
      #1;
      check("t6_rst_ctrl", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid,
                                 busy, mem_rd_en, mem_rd_addr}), 64'd0);
      check("t6_rst_rdata", s_axi_rdata, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rv_seen = 0;
      @(negedge clk);
      check("t6_arready", 64'(s_axi_arready), 64'd1);
      for (int c = 0; c < 4; c++) begin
         if (s_axi_rvalid) rv_seen++;
         @(negedge clk);
      end
      check("t6_no_stale", 64'(rv_seen), 64'd0);
      do_burst(4'h1, 30'h18, 8'd0, 2'b01, 32'hFFFF_FFFF);
      check("t6_nbeats", 64'(q_data.size()), 64'd1);
      if (q_data.size() > 0) begin
         check("t6_data", q_data[0], 64'd103);
         check("t6_latency", 64'(q_cyc[0]), 64'd3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
